// File: rtl/twos_complement_ctrl_if.sv
// =============================================================================
// twos_complement_ctrl_if : operand/result handshake bundle for the serial
//                           two's-complement sequencer.       Rev 1.0
// =============================================================================
`default_nettype none

interface twos_complement_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] data_in;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic             result_ovf;

  modport master (
    output start_valid, data_in, result_ready,
    input  start_ready, result_valid, result, result_ovf
  );

  modport slave (
    input  start_valid, data_in, result_ready,
    output start_ready, result_valid, result, result_ovf
  );
endinterface

`default_nettype wire

// File: rtl/twos_complement_ctrl.sv
// =============================================================================
// twos_complement_ctrl : parallel<->serial sequencer around the bit-serial
//                        negation core (clear, shift LSB-first, reassemble).
// Rev 1.0
// =============================================================================
`default_nettype none

module twos_complement_ctrl #(
  parameter int WIDTH = 16
) (
  input  wire logic               clk,
  input  wire logic               reset,
  twos_complement_ctrl_if.slave   bus,
  output logic                    busy,
  output logic                    ser_in,
  output logic                    ser_clr,
  input  wire logic               ser_out
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_ovf_word = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             r_result_valid;
  logic             r_start_ready;
  logic             r_busy;
  logic             r_ser_in;
  logic             r_ser_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_operand      <= '0;
      r_result       <= '0;
      r_ovf          <= 1'b0;
      r_result_valid <= 1'b0;
      r_start_ready  <= 1'b0;
      r_busy         <= 1'b0;
      r_ser_in       <= 1'b0;
      r_ser_clr      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ser_clr <= 1'b0;
          r_ser_in  <= 1'b0;
          if (r_start_ready && bus.start_valid) begin
            r_operand     <= bus.data_in;
            r_ovf         <= (bus.data_in == c_ovf_word);
            r_cnt         <= '0;
            r_state       <= S_CLEAR;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_ser_clr     <= 1'b1;
          end else begin
            // Ready comes up one edge after reset release or a result handshake.
            r_start_ready <= 1'b1;
          end
        end

        S_CLEAR: begin
          r_state   <= S_SHIFT;
          r_ser_clr <= 1'b0;
          r_ser_in  <= r_operand[0];
        end

        S_SHIFT: begin
          // The core output is Mealy in ser_in, so capture it on the same edge.
          r_result  <= {ser_out, r_result[WIDTH-1:1]};
          r_operand <= {1'b0, r_operand[WIDTH-1:1]};
          if (r_cnt == c_last_cnt) begin
            r_state        <= S_DONE;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b1;
            r_ser_in       <= 1'b0;
          end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_ser_in <= r_operand[1];
          end
        end

        S_DONE: begin
          if (bus.result_ready) begin
            r_state        <= S_IDLE;
            r_result_valid <= 1'b0;
            r_start_ready  <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready  = r_start_ready;
  assign bus.result_valid = r_result_valid;
  assign bus.result       = r_result;
  assign bus.result_ovf   = r_ovf;
  assign busy             = r_busy;
  assign ser_in           = r_ser_in;
  assign ser_clr          = r_ser_clr;

endmodule

`default_nettype wire
